lfsr_bank: RTL and testbench

- Bank of NUM_CH independent Fibonacci LFSRs with parametrised width, tap polynomial and leap-ahead step count.
- All channels advance in lock-step and present one sample vector on a valid/ready stream.
- Feeds the Monte-Carlo sampling pipeline, e.g. NUM_CH=2 gives the x/y coordinate pair per sample.
- Supports per-channel runtime seeding and all-zero lock-up protection.

---
 rtl/lfsr_pkg.sv | 36 +++
 rtl/lfsr_core.sv | 61 ++++++
 rtl/lfsr_bank.sv | 121 ++++++++++++
 tb/tb_lfsr_bank.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR bank.
// Contents: the single-step Fibonacci update, the default tap masks, and the
// seed-index width helper.
package lfsr_pkg;

    // Widest state the step helper handles. Narrower states are zero-extended.
    localparam int LFSR_MAX_W = 64;

    // Default tap masks for common widths.
    localparam logic [3:0]  LFSR_POLY_4  = 4'hC;
    localparam logic [7:0]  LFSR_POLY_8  = 8'hB8;
    localparam logic [15:0] LFSR_POLY_16 = 16'hB400;
    localparam logic [31:0] LFSR_POLY_32 = 32'h80200003;

    // Width of the seed channel selector. It is at least one bit, even for a single channel.
    function automatic int seed_idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // One Fibonacci shift of a width-bit state held in the low bits:
    //   next = {s[width-2:0], ^(s & poly)}
    // Bits at or above width are forced to zero on return.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] poly,
        input int                    width
    );
        logic [LFSR_MAX_W-1:0] mask;
        logic                  fb;
        mask = (width >= LFSR_MAX_W) ? {LFSR_MAX_W{1'b1}}
                                     : ((LFSR_MAX_W'(1) << width) - LFSR_MAX_W'(1));
        fb   = ^(state & poly & mask);
        return ((state << 1) | LFSR_MAX_W'(fb)) & mask;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// One LFSR channel.
// The channel holds the state and applies STEPS unrolled shifts on each advance.
// It loads a runtime seed. A zero seed is replaced by CH_INDEX+1, because the
// all-zero state would lock up.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] POLY      = LFSR_POLY_32,
    parameter int               OUT_WIDTH = 16,
    parameter int               STEPS     = 1,
    parameter int               CH_INDEX  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 advance_i,
    input  logic                 load_i,
    input  logic [WIDTH-1:0]     seed_data_i,
    output logic [OUT_WIDTH-1:0] sample_o
);

    // The reset value doubles as the substitute for an all-zero seed.
    localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(CH_INDEX + 1);

    logic [WIDTH-1:0]      state_q;
    logic [WIDTH-1:0]      state_d;
    logic [WIDTH-1:0]      next_state;
    logic [LFSR_MAX_W-1:0] stepped_full;

    // Unroll STEPS single shifts into one combinational leap-ahead.
    always_comb begin
        stepped_full = LFSR_MAX_W'(state_q);
        for (int k = 0; k < STEPS; k++) begin
            stepped_full = lfsr_step(stepped_full, LFSR_MAX_W'(POLY), WIDTH);
        end
        next_state = WIDTH'(stepped_full);
    end

    // The sample is taken from the post-advance state, so it is registered together with it.
    assign sample_o = next_state[OUT_WIDTH-1:0];

    // Next state: a seed load wins; otherwise the state advances or holds.
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = (seed_data_i == '0) ? RESET_VAL : seed_data_i;
        end else if (advance_i) begin
            state_d = next_state;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESET_VAL;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/lfsr_bank.sv
// Bank of NUM_CH lock-step Fibonacci LFSRs behind a valid/ready output register.
// Optional feature: define LFSR_BANK_STATS_EN to add a 32-bit sample_count
// output. It counts completed transfers since reset.
module lfsr_bank
    import lfsr_pkg::*;
#(
    parameter int               NUM_CH    = 2,
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] POLY      = LFSR_POLY_32,
    parameter int               OUT_WIDTH = 16,
    parameter int               STEPS     = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic [WIDTH-1:0]                  seed_data,
    input  logic [seed_idx_width(NUM_CH)-1:0] seed_ch,
    input  logic                              seed_wr,
    output logic [NUM_CH*OUT_WIDTH-1:0]       dout,
    output logic                              dout_valid,
    input  logic                              dout_ready,
    output logic                              lockup
`ifdef LFSR_BANK_STATS_EN
    ,
    output logic [31:0]                       sample_count
`endif
);

    localparam int SEED_CH_W = seed_idx_width(NUM_CH);

    logic                        advance;
    logic                        transfer;
    logic                        seed_zero;
    logic [NUM_CH-1:0]           load_vec;
    logic [NUM_CH*OUT_WIDTH-1:0] sample_all;

    logic [NUM_CH*OUT_WIDTH-1:0] dout_q;
    logic [NUM_CH*OUT_WIDTH-1:0] dout_d;
    logic                        dout_valid_q;
    logic                        dout_valid_d;
    logic                        lockup_q;
    logic                        lockup_d;

    // A seed write stalls the whole bank. A full, unaccepted output register also stalls it.
    assign advance   = enable && !seed_wr && (!dout_valid_q || dout_ready);
    assign transfer  = dout_valid_q && dout_ready;
    assign seed_zero = (seed_data == '0);

    // One core per channel. An out-of-range seed_ch matches no core, so it loads nothing.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign load_vec[gi] = seed_wr && (seed_ch == SEED_CH_W'(gi));

        lfsr_core #(
            .WIDTH     (WIDTH),
            .POLY      (POLY),
            .OUT_WIDTH (OUT_WIDTH),
            .STEPS     (STEPS),
            .CH_INDEX  (gi)
        ) u_core (
            .clk         (clk),
            .reset       (reset),
            .advance_i   (advance),
            .load_i      (load_vec[gi]),
            .seed_data_i (seed_data),
            .sample_o    (sample_all[gi*OUT_WIDTH +: OUT_WIDTH])
        );
    end

    // Output register and handshake. An accepted sample with no refill empties the register.
    // The lockup flag sets only when a zero seed actually reaches a channel.
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        if (advance) begin
            dout_d       = sample_all;
            dout_valid_d = 1'b1;
        end else if (transfer) begin
            dout_valid_d = 1'b0;
        end
        lockup_d = lockup_q | ((|load_vec) && seed_zero);
    end

    // Output and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            lockup_q     <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            lockup_q     <= lockup_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign lockup     = lockup_q;

`ifdef LFSR_BANK_STATS_EN
    logic [31:0] sample_count_q;
    logic [31:0] sample_count_d;

    // Count completed transfers. The counter wraps naturally at 2^32.
    always_comb begin
        sample_count_d = sample_count_q + (transfer ? 32'd1 : 32'd0);
    end

    // Transfer counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_count_q <= '0;
        end else begin
            sample_count_q <= sample_count_d;
        end
    end

    assign sample_count = sample_count_q;
`endif

endmodule

// File: tb/tb_lfsr_bank.sv
// Directed testbench for lfsr_bank.
// u_one: 1 channel, 4-bit state, poly 4'hC, 1 step per sample.
// u_two: 2 channels, same polynomial, 2 steps per sample.
module tb_lfsr_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;

    // Single-channel instance signals.
    logic       en1 = 1'b0;
    logic [3:0] sd1 = '0;
    logic [0:0] sc1 = '0;
    logic       sw1 = 1'b0;
    logic       rdy1 = 1'b0;
    logic [3:0] dout1;
    logic       v1;
    logic       lk1;

    // Two-channel instance signals.
    logic       en2 = 1'b0;
    logic [3:0] sd2 = '0;
    logic [0:0] sc2 = '0;
    logic       sw2 = 1'b0;
    logic       rdy2 = 1'b0;
    logic [7:0] dout2;
    logic       v2;
    logic       lk2;

`ifdef LFSR_BANK_STATS_EN
    logic [31:0] cnt1;
    logic [31:0] cnt2;
`endif

    lfsr_bank #(
        .NUM_CH(1), .WIDTH(4), .POLY(4'hC), .OUT_WIDTH(4), .STEPS(1)
    ) u_one (
        .clk        (clk),
        .reset      (reset),
        .enable     (en1),
        .seed_data  (sd1),
        .seed_ch    (sc1),
        .seed_wr    (sw1),
        .dout       (dout1),
        .dout_valid (v1),
        .dout_ready (rdy1),
        .lockup     (lk1)
`ifdef LFSR_BANK_STATS_EN
        ,
        .sample_count (cnt1)
`endif
    );

    lfsr_bank #(
        .NUM_CH(2), .WIDTH(4), .POLY(4'hC), .OUT_WIDTH(4), .STEPS(2)
    ) u_two (
        .clk        (clk),
        .reset      (reset),
        .enable     (en2),
        .seed_data  (sd2),
        .seed_ch    (sc2),
        .seed_wr    (sw2),
        .dout       (dout2),
        .dout_valid (v2),
        .dout_ready (rdy2),
        .lockup     (lk2)
`ifdef LFSR_BANK_STATS_EN
        ,
        .sample_count (cnt2)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Hand-derived states of x^4 taps {3,2} starting from 1: seq[k] is the state after k shifts.
    int seq [0:14] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};
    int p;
    int p0;
    int p1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp2(input int a, input int b);
        return 32'((seq[b] << 4) | seq[a]);
    endfunction

    initial begin
        // Reset state.
        tick();
        tick();
        check("rst1_dout", 32'(dout1), 32'd0);
        check("rst1_valid", 32'(v1), 32'd0);
        check("rst1_lockup", 32'(lk1), 32'd0);
        check("rst2_dout", 32'(dout2), 32'd0);
        check("rst2_valid", 32'(v2), 32'd0);
        check("rst2_lockup", 32'(lk2), 32'd0);

        // Single channel, full period plus wrap.
        reset = 1'b0;
        en1 = 1'b1;
        rdy1 = 1'b1;
        p = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            p = (p + 1) % 15;
            check("one_seq", 32'(dout1), 32'(seq[p]));
            check("one_valid", 32'(v1), 32'd1);
            $display("one: sample %0d dout=%0d", i, dout1);
        end

        // With enable low, the accepted sample is not refilled and dout holds.
        en1 = 1'b0;
        tick();
        check("one_enlow_valid", 32'(v1), 32'd0);
        check("one_enlow_dout", 32'(dout1), 32'(seq[p]));
        en1 = 1'b1;
        tick();
        p = (p + 1) % 15;
        check("one_resume", 32'(dout1), 32'(seq[p]));

        // Out-of-range channel (1 with NUM_CH=1) and a zero seed: only the stall happens.
        sw1 = 1'b1;
        sc1 = 1'b1;
        sd1 = 4'h0;
        tick();
        check("one_badch_valid", 32'(v1), 32'd0);
        check("one_badch_dout", 32'(dout1), 32'(seq[p]));
        check("one_badch_lockup", 32'(lk1), 32'd0);
        sw1 = 1'b0;
        tick();
        p = (p + 1) % 15;
        check("one_badch_next", 32'(dout1), 32'(seq[p]));
        $display("one: after invalid seed dout=%0d", dout1);

        // Two channels, leap of 2 steps. ch0 starts at seq[0], ch1 at seq[1].
        en2 = 1'b1;
        rdy2 = 1'b1;
        p0 = 0;
        p1 = 1;
        tick();
        p0 = (p0 + 2) % 15;
        p1 = (p1 + 2) % 15;
        check("two_first", 32'(dout2), exp2(p0, p1));
        check("two_first_valid", 32'(v2), 32'd1);

        // Backpressure: dout and valid are frozen.
        rdy2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("two_bp_dout", 32'(dout2), exp2(p0, p1));
            check("two_bp_valid", 32'(v2), 32'd1);
            $display("two: backpressure cycle %0d dout=%02h", i, dout2);
        end
        rdy2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            p0 = (p0 + 2) % 15;
            p1 = (p1 + 2) % 15;
            check("two_after_bp", 32'(dout2), exp2(p0, p1));
            $display("two: stream dout=%02h", dout2);
        end

        // Seed ch1 with 7 (= seq[10]) while streaming.
        sw2 = 1'b1;
        sc2 = 1'b1;
        sd2 = 4'h7;
        tick();
        check("two_seed_valid", 32'(v2), 32'd0);
        check("two_seed_dout", 32'(dout2), exp2(p0, p1));
        p1 = 10;
        sw2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            p0 = (p0 + 2) % 15;
            p1 = (p1 + 2) % 15;
            check("two_after_seed", 32'(dout2), exp2(p0, p1));
            $display("two: after seed dout=%02h", dout2);
        end

        // A zero seed on ch0 loads 1 and sets the sticky lockup flag.
        sw2 = 1'b1;
        sc2 = 1'b0;
        sd2 = 4'h0;
        tick();
        check("two_zero_lockup", 32'(lk2), 32'd1);
        check("two_zero_valid", 32'(v2), 32'd0);
        check("two_zero_dout", 32'(dout2), exp2(p0, p1));
        p0 = 0;
        sw2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            p0 = (p0 + 2) % 15;
            p1 = (p1 + 2) % 15;
            check("two_after_zero", 32'(dout2), exp2(p0, p1));
            check("two_lockup_sticky", 32'(lk2), 32'd1);
            $display("two: after zero seed dout=%02h lockup=%0d", dout2, lk2);
        end

        // Reset with a pending sample discards it.
        check("two_pre_reset_valid", 32'(v2), 32'd1);
        reset = 1'b1;
        tick();
        check("two_reset_valid", 32'(v2), 32'd0);
        check("two_reset_dout", 32'(dout2), 32'd0);
        check("two_reset_lockup", 32'(lk2), 32'd0);
`ifdef LFSR_BANK_STATS_EN
        check("two_reset_count", cnt2, 32'd0);
`endif

        // 101 advances yield 100 completed transfers.
        reset = 1'b0;
        p0 = 0;
        p1 = 1;
        for (int i = 0; i < 101; i++) begin
            tick();
            p0 = (p0 + 2) % 15;
            p1 = (p1 + 2) % 15;
        end
        check("two_long_dout", 32'(dout2), exp2(p0, p1));
        $display("two: after 101 advances dout=%02h", dout2);
`ifdef LFSR_BANK_STATS_EN
        check("two_count_100", cnt2, 32'd100);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
